wb_raxm_ctrl: RTL and testbench
===============================

// Module: wb_raxm_ctrl
// PURPOSE
//  Wishbone-classic slave front-end in the Caravel user area that feeds the RAxM approximate multiplier core.
//  Firmware writes operands and mode, then pulses START; the block issues the request over a valid/ready handshake.
//  It collects the core's result into a 4-deep result FIFO, which firmware pops by reading RESULT.
//  The IRQ and the sticky status bits let the firmware test (0xAB60/0xAB61 on mprj_io[31:16]) sequence and check it.
// PARAMETERS
//  BASE_ADDR   32'h3000_0000  slave window; decode is wbs_adr_i[31:8]==BASE_ADDR[31:8]
//  OP_W        16             operand width; result width is 2*OP_W
//  MODE_W      3              approximation-level field width (0 = exact)
//  FIFO_DEPTH  4              result FIFO entries (power of two)
//  TIMEOUT     255            max cycles in WAIT before abort
// PORTS
//  wb_clk_i         in   1        system clock
//  wb_rst_n         in   1        async active-low reset
//  wbs_cyc_i        in   1        WB cycle
//  wbs_stb_i        in   1        WB strobe
//  wbs_we_i         in   1        WB write enable
//  wbs_sel_i        in   4        WB byte enables
//  wbs_adr_i        in   32       WB address
//  wbs_dat_i        in   32       WB write data
//  wbs_ack_o        out  1        WB acknowledge
//  wbs_dat_o        out  32       WB read data
//  mul_a_o          out  OP_W     operand A to core (latched at START)
//  mul_b_o          out  OP_W     operand B to core (latched at START)
//  mul_mode_o       out  MODE_W   approximation mode to core
//  mul_valid_o      out  1        request valid
//  mul_ready_i      in   1        core accepts request
//  mul_res_i        in   2*OP_W   core result
//  mul_res_valid_i  in   1        result strobe, 1 cycle
//  irq_o            out  1        level interrupt
// BEHAVIOUR
//  Reset: all outputs 0; all registers 0; FIFO empty; FSM in IDLE.
//  Register map (offsets from BASE_ADDR):
//   0x00 CTRL: [0] START (write 1, self-clears), [1] IRQ_EN, [6:4] MODE.
//   0x04 OPA[15:0]; 0x08 OPB[15:0].
//   0x0C RESULT: read returns the FIFO head and pops it; read on empty returns 0 and does not pop.
//   0x10 STATUS: [0] busy, [1] empty, [2] full, [3] TMO sticky, [4] DROP sticky, [10:8] count.
//    TMO and DROP are write-1-to-clear.
//  WB: wbs_ack_o asserts 1 cycle after cyc&stb with a decoded address, for exactly 1 cycle, never on back-to-back cycles.
//   Addresses outside the window are never acked. Addresses inside the window but unmapped: acked, read 0, writes ignored.
//   The write side effect and the read pop happen on the ack cycle. Byte enables apply to OPA/OPB; CTRL needs sel[0].
//  FSM:
//   IDLE: START with FIFO not full latches OPA/OPB/MODE -> ISSUE.
//    START while FIFO is full, or in any state other than IDLE: ignored and sets DROP.
//   ISSUE: mul_valid_o=1, operands held stable; on mul_ready_i -> WAIT and clear the timeout counter.
//   WAIT: on mul_res_valid_i, push mul_res_i -> IDLE. If the counter reaches TIMEOUT: set TMO, no push -> IDLE.
//  busy = (state != IDLE). OPA/OPB/MODE writes during busy update the registers only, not the in-flight request.
//  FIFO: push and pop in the same cycle leaves count unchanged and data stays ordered. Pointers wrap modulo FIFO_DEPTH.
//  mul_res_valid_i outside WAIT is ignored.
//  irq_o = IRQ_EN & !empty, registered (1-cycle lag).
//  Reset mid-operation: aborts immediately; FIFO is flushed and any late mul_res_valid_i is ignored.
// STRUCTURE
//  raxm_pkg: register offsets, CTRL/STATUS bit indices, FSM state enum (IDLE/ISSUE/WAIT), TIMEOUT default.
//  One sub-module, raxm_result_fifo: synchronous FIFO with count, full and empty outputs and simultaneous push/pop.
//   Decode, the register file and the FSM stay in wb_raxm_ctrl.
// TESTING
//  1. OPA=0x0012, OPB=0x0034, MODE=0, START; core model ready after 2 cycles, result 0x3A8 after 3
//     -> STATUS busy=1 then count=1; RESULT reads 0x0000_03A8; count=0.
//  2. Four STARTs with no reads, then a fifth -> full=1, DROP=1, count=4; reads return the four results in order.
//  3. Core model never returns a result -> after 255 WAIT cycles TMO=1, busy=0, count=0; W1C clears TMO.
//  4. Pop on the same cycle as a push with count=2 -> count stays 2 and the next read returns the older entry.
//  5. Read at 0x3000_0100 -> no ack. Read RESULT when empty -> 0, count unchanged.
//  6. Assert wb_rst_n low during ISSUE -> mul_valid_o=0 at once; STATUS reads 0x0002 after release.

Source files
------------

// File: rtl/raxm_pkg.sv
// Shared definitions for the RAxM Wishbone front-end: register map, bit
// positions and the request FSM encoding.
package raxm_pkg;

   // Register byte offsets inside the 256-byte slave window
   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_OPA    = 8'h04;
   localparam logic [7:0] OFF_OPB    = 8'h08;
   localparam logic [7:0] OFF_RESULT = 8'h0C;
   localparam logic [7:0] OFF_STATUS = 8'h10;

   // CTRL bit positions
   localparam int unsigned CTRL_START    = 0;
   localparam int unsigned CTRL_IRQ_EN   = 1;
   localparam int unsigned CTRL_MODE_LSB = 4;

   // STATUS bit positions
   localparam int unsigned ST_BUSY      = 0;
   localparam int unsigned ST_EMPTY     = 1;
   localparam int unsigned ST_FULL      = 2;
   localparam int unsigned ST_TMO       = 3;
   localparam int unsigned ST_DROP      = 4;
   localparam int unsigned ST_COUNT_LSB = 8;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } raxm_state_e;

endpackage

// File: rtl/raxm_result_fifo.sv
// Synchronous result FIFO with occupancy count. Push and pop may occur in the
// same cycle; a push while full is only taken if a pop frees a slot.
module raxm_result_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_en, pop_en;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign pop_en  = pop_i & ~empty_o;
   assign push_en = push_i & (~full_o | pop_en);

   // Storage, pointers (wrap naturally at DEPTH) and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_en, pop_en})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/wb_raxm_ctrl.sv
// Wishbone-classic slave that sequences requests into the RAxM approximate
// multiplier and buffers its results for firmware to pop.
module wb_raxm_ctrl
   import raxm_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int unsigned OP_W       = 16,
   parameter int unsigned MODE_W     = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic [OP_W-1:0]   mul_a_o,
   output logic [OP_W-1:0]   mul_b_o,
   output logic [MODE_W-1:0] mul_mode_o,
   output logic              mul_valid_o,
   input  logic              mul_ready_i,
   input  logic [2*OP_W-1:0] mul_res_i,
   input  logic              mul_res_valid_i,
   output logic              irq_o
);

   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
   localparam int unsigned OP_BYTES = OP_W / 8;

   raxm_state_e       state_q, state_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [OP_W-1:0]   opa_q, opa_d, opb_q, opb_d;
   logic [OP_W-1:0]   req_a_q, req_a_d, req_b_q, req_b_d;
   logic [MODE_W-1:0] mode_q, mode_d, req_mode_q, req_mode_d;
   logic              irq_en_q, irq_en_d, tmo_q, tmo_d, drop_q, drop_d;
   logic              ack_q, irq_q;

   logic              hit, acc, wr_acc, rd_acc;
   logic [7:0]        off;
   logic              start_req, start_ok, drop_set, tmo_set, push, pop;
   logic [31:0]       rdata;

   logic [2*OP_W-1:0] fifo_rdata;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty;

   // Byte lanes above the operand width carry nothing for this block
   logic unused_bits;
   assign unused_bits = ^{wbs_sel_i[3:OP_BYTES], wbs_dat_i[31:OP_W]};

   assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign off    = wbs_adr_i[7:0];
   // Side effects land on the edge that closes the ack cycle
   assign acc    = ack_q & wbs_cyc_i & wbs_stb_i;
   assign wr_acc = acc & wbs_we_i;
   assign rd_acc = acc & ~wbs_we_i;

   assign start_req = wr_acc & (off == OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_START];
   assign start_ok  = start_req & (state_q == StIdle) & ~fifo_full;
   assign drop_set  = start_req & ~start_ok;
   assign pop       = rd_acc & (off == OFF_RESULT);

   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = ack_q ? rdata : 32'h0;
   assign mul_a_o     = req_a_q;
   assign mul_b_o     = req_b_q;
   assign mul_mode_o  = req_mode_q;
   assign mul_valid_o = (state_q == StIssue);
   assign irq_o       = irq_q;

   raxm_result_fifo #(
      .WIDTH (2 * OP_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_ni  (wb_rst_n),
      .push_i  (push),
      .wdata_i (mul_res_i),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Request FSM: latch operands on START, hold during ISSUE, bound WAIT
   always_comb begin
      state_d    = state_q;
      tmo_cnt_d  = tmo_cnt_q;
      req_a_d    = req_a_q;
      req_b_d    = req_b_q;
      req_mode_d = req_mode_q;
      push       = 1'b0;
      tmo_set    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d    = StIssue;
               req_a_d    = opa_q;
               req_b_d    = opb_q;
               // MODE travels in the same CTRL write as START
               req_mode_d = wbs_dat_i[CTRL_MODE_LSB +: MODE_W];
            end
         end
         StIssue: begin
            if (mul_ready_i) begin
               state_d   = StWait;
               tmo_cnt_d = '0;
            end
         end
         StWait: begin
            if (mul_res_valid_i) begin
               push    = 1'b1;
               state_d = StIdle;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
               tmo_set = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Register file writes; sticky sets win over a same-cycle W1C
   always_comb begin
      opa_d    = opa_q;
      opb_d    = opb_q;
      mode_d   = mode_q;
      irq_en_d = irq_en_q;
      tmo_d    = tmo_q;
      drop_d   = drop_q;
      if (wr_acc) begin
         case (off)
            OFF_CTRL: begin
               if (wbs_sel_i[0]) begin
                  irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
                  mode_d   = wbs_dat_i[CTRL_MODE_LSB +: MODE_W];
               end
            end
            OFF_OPA: begin
               for (int b = 0; b < int'(OP_BYTES); b++)
                  if (wbs_sel_i[b]) opa_d[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
            end
            OFF_OPB: begin
               for (int b = 0; b < int'(OP_BYTES); b++)
                  if (wbs_sel_i[b]) opb_d[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
            end
            OFF_STATUS: begin
               if (wbs_dat_i[ST_TMO])  tmo_d  = 1'b0;
               if (wbs_dat_i[ST_DROP]) drop_d = 1'b0;
            end
            default: ;
         endcase
      end
      if (tmo_set)  tmo_d  = 1'b1;
      if (drop_set) drop_d = 1'b1;
   end

   // Read mux; unmapped offsets and an empty RESULT read as zero
   always_comb begin
      rdata = 32'h0;
      case (off)
         OFF_CTRL: begin
            rdata[CTRL_IRQ_EN]              = irq_en_q;
            rdata[CTRL_MODE_LSB +: MODE_W] = mode_q;
         end
         OFF_OPA:    rdata[OP_W-1:0] = opa_q;
         OFF_OPB:    rdata[OP_W-1:0] = opb_q;
         OFF_RESULT: if (!fifo_empty) rdata[2*OP_W-1:0] = fifo_rdata;
         OFF_STATUS: begin
            rdata[ST_BUSY]                  = (state_q != StIdle);
            rdata[ST_EMPTY]                 = fifo_empty;
            rdata[ST_FULL]                  = fifo_full;
            rdata[ST_TMO]                   = tmo_q;
            rdata[ST_DROP]                  = drop_q;
            rdata[ST_COUNT_LSB +: CNT_W]    = fifo_count;
         end
         default: ;
      endcase
   end

   // State registers, single-cycle ack that can never fire back-to-back
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q    <= StIdle;
         tmo_cnt_q  <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         mode_q     <= '0;
         irq_en_q   <= 1'b0;
         tmo_q      <= 1'b0;
         drop_q     <= 1'b0;
         req_a_q    <= '0;
         req_b_q    <= '0;
         req_mode_q <= '0;
         ack_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_cnt_q  <= tmo_cnt_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         mode_q     <= mode_d;
         irq_en_q   <= irq_en_d;
         tmo_q      <= tmo_d;
         drop_q     <= drop_d;
         req_a_q    <= req_a_d;
         req_b_q    <= req_b_d;
         req_mode_q <= req_mode_d;
         ack_q      <= wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
         irq_q      <= irq_en_q & ~fifo_empty;
      end
   end

endmodule

// File: tb/tb_wb_raxm_ctrl.sv
// Scoreboarded bench for wb_raxm_ctrl: reads push their expected data, a
// monitor pops and compares on every read acknowledge.
module tb_wb_raxm_ctrl;

   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam logic [31:0] A_CTRL = BASE + 32'h00;
   localparam logic [31:0] A_OPA  = BASE + 32'h04;
   localparam logic [31:0] A_OPB  = BASE + 32'h08;
   localparam logic [31:0] A_RES  = BASE + 32'h0C;
   localparam logic [31:0] A_STAT = BASE + 32'h10;

   logic        clk, rst_n;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat;
   logic        ack;
   logic [31:0] rdat;
   logic [15:0] mul_a, mul_b;
   logic [2:0]  mul_mode;
   logic        mul_valid;
   logic        m_ready, m_res_valid, tb_res_valid;
   logic [31:0] m_res, tb_res;
   logic        irq;

   int core_mode;  // 0 normal, 1 ready but no result, 2 never ready
   int checks, errors;

   typedef struct {
      logic [31:0] d;
      string       n;
   } exp_t;
   exp_t exp_q[$];

   wb_raxm_ctrl dut (
      .wb_clk_i        (clk),
      .wb_rst_n        (rst_n),
      .wbs_cyc_i       (cyc),
      .wbs_stb_i       (stb),
      .wbs_we_i        (we),
      .wbs_sel_i       (sel),
      .wbs_adr_i       (adr),
      .wbs_dat_i       (dat),
      .wbs_ack_o       (ack),
      .wbs_dat_o       (rdat),
      .mul_a_o         (mul_a),
      .mul_b_o         (mul_b),
      .mul_mode_o      (mul_mode),
      .mul_valid_o     (mul_valid),
      .mul_ready_i     (m_ready),
      .mul_res_i       (m_res_valid ? m_res : tb_res),
      .mul_res_valid_i (m_res_valid | tb_res_valid),
      .irq_o           (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Core model: ready one cycle after valid is seen, result three cycles later
   initial begin
      logic [15:0] la, lb;
      m_ready = 1'b0;
      m_res_valid = 1'b0;
      m_res = '0;
      forever begin
         @(negedge clk);
         if (mul_valid && core_mode != 2) begin
            la = mul_a;
            lb = mul_b;
            @(posedge clk); #1 m_ready = 1'b1;
            @(posedge clk); #1 m_ready = 1'b0;
            if (core_mode == 0) begin
               @(posedge clk);
               @(posedge clk); #1;
               m_res_valid = 1'b1;
               m_res = {16'h0, la} * {16'h0, lb};
               @(posedge clk); #1 m_res_valid = 1'b0;
            end
         end
      end
   end

   // Monitor: every read acknowledge consumes one scoreboard entry
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ack && !we) begin
            if (exp_q.size() == 0) begin
               chk("unexpected read ack", rdat, 32'hxxxx_xxxx);
            end else begin
               e = exp_q.pop_front();
               chk(e.n, rdat, e.d);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the ack cycle closed
   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
      int n = 0;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 20);
      if (!ack) begin
         checks++;
         errors++;
         $display("FAIL ack timeout: addr 0x%08h got no ack, required ack within 20 cycles", a);
         if (!w && exp_q.size() > 0) void'(exp_q.pop_back());
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wb_xfer(1'b1, a, d, 4'hF);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string name);
      exp_t x;
      x.d = e;
      x.n = name;
      exp_q.push_back(x);
      wb_xfer(1'b0, a, 32'h0, 4'hF);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [15:0] a, input logic [15:0] b, input logic [31:0] ctrl);
      wr(A_OPA, {16'h0, a});
      wr(A_OPB, {16'h0, b});
      wr(A_CTRL, ctrl);
   endtask

   // STATUS: [0] busy [1] empty [2] full [3] tmo [4] drop [10:8] count
   initial begin
      int acks;
      checks = 0; errors = 0; core_mode = 0;
      cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
      tb_res = 0; tb_res_valid = 0;
      rst_n = 1'b0;
      idle(3);
      chk("reset mul_valid", {31'h0, mul_valid}, 32'h0);
      chk("reset irq", {31'h0, irq}, 32'h0);
      chk("reset ack", {31'h0, ack}, 32'h0);
      chk("reset mul_a", {16'h0, mul_a}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      rd(A_STAT, 32'h002, "reset status");
      rd(A_CTRL, 32'h000, "reset ctrl");

      // Byte enables on OPB
      wr(A_OPB, 32'h0000_FFFF);
      wb_xfer(1'b1, A_OPB, 32'h0000_0012, 4'b0001);
      rd(A_OPB, 32'h0000_FF12, "opb byte lane");

      // 1: single multiply with IRQ enabled
      start(16'h0012, 16'h0034, 32'h3);
      rd(A_STAT, 32'h003, "t1 busy");
      idle(10);
      rd(A_STAT, 32'h100, "t1 count1");
      chk("t1 irq set", {31'h0, irq}, 32'h1);
      rd(A_RES, 32'h0000_03A8, "t1 result");
      idle(1);
      chk("t1 irq clear", {31'h0, irq}, 32'h0);
      rd(A_STAT, 32'h002, "t1 empty");

      // 2: fill the FIFO, fifth START is dropped
      start(16'd3, 16'd5, 32'h1);
      idle(10);
      start(16'h0100, 16'h0100, 32'h51);
      chk("t2 valid", {31'h0, mul_valid}, 32'h1);
      chk("t2 mode", {29'h0, mul_mode}, 32'h5);
      chk("t2 opa latched", {16'h0, mul_a}, 32'h0100);
      wr(A_OPA, 32'h0000_BEEF);
      chk("t2 opa held", {16'h0, mul_a}, 32'h0100);
      idle(10);
      rd(A_OPA, 32'h0000_BEEF, "t2 opa reg");
      rd(A_CTRL, 32'h50, "t2 ctrl");
      start(16'hFFFF, 16'hFFFF, 32'h1);
      idle(10);
      start(16'd7, 16'd0, 32'h1);
      idle(10);
      wr(A_CTRL, 32'h1);
      idle(5);
      rd(A_STAT, 32'h414, "t2 full drop");
      rd(A_RES, 32'h0000_000F, "t2 res0");
      rd(A_RES, 32'h0001_0000, "t2 res1");
      rd(A_RES, 32'hFFFE_0001, "t2 res2");
      rd(A_RES, 32'h0000_0000, "t2 res3");
      rd(A_STAT, 32'h012, "t2 drop sticky");
      wr(A_STAT, 32'h10);
      rd(A_STAT, 32'h002, "t2 drop w1c");

      // 3: timeout
      core_mode = 1;
      start(16'd9, 16'd9, 32'h1);
      idle(100);
      rd(A_STAT, 32'h003, "t3 still waiting");
      idle(200);
      rd(A_STAT, 32'h00A, "t3 tmo");
      wr(A_STAT, 32'h08);
      rd(A_STAT, 32'h002, "t3 tmo w1c");

      // 4: pop coincides with push at count 2
      core_mode = 0;
      start(16'd10, 16'd10, 32'h1);
      idle(10);
      start(16'd2, 16'd3, 32'h1);
      idle(10);
      core_mode = 1;
      start(16'd4, 16'd4, 32'h1);
      idle(10);
      begin
         exp_t x;
         x.d = 32'h64;
         x.n = "t4 pop during push";
         exp_q.push_back(x);
      end
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_RES; sel = 4'hF;
      @(posedge clk); #1;
      tb_res_valid = 1'b1; tb_res = 32'h0000_CAFE;
      @(posedge clk); #1;
      tb_res_valid = 1'b0; cyc = 1'b0; stb = 1'b0;
      rd(A_STAT, 32'h200, "t4 count2");
      rd(A_RES, 32'h0000_0006, "t4 older");
      rd(A_RES, 32'h0000_CAFE, "t4 newer");

      // 5: empty read, stray result strobe, out-of-window address
      rd(A_RES, 32'h0, "t5 empty read");
      tb_res_valid = 1'b1; tb_res = 32'h1234_5678;
      idle(1);
      tb_res_valid = 1'b0;
      rd(A_STAT, 32'h002, "t5 status");
      acks = 0;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100;
      repeat (6) begin
         @(negedge clk);
         if (ack) acks++;
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      chk("t5 out of window acks", acks, 0);

      // 6: reset while ISSUE is pending
      core_mode = 0;
      start(16'd1, 16'd1, 32'h1);
      idle(10);
      core_mode = 2;
      start(16'd5, 16'd6, 32'h3);
      chk("t6 issuing", {31'h0, mul_valid}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t6 valid drops", {31'h0, mul_valid}, 32'h0);
      chk("t6 opa cleared", {16'h0, mul_a}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      rd(A_STAT, 32'h002, "t6 status");
      rd(A_CTRL, 32'h000, "t6 ctrl");
      idle(3);

      chk("scoreboard drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
